// File: rtl/uart_reg_pkg.sv
// Shared types and widths for the UART register bridge.
// Optional feature macro: UART_REG_TIMEOUT_EN (inter-byte timeout while waiting for write data).
package uart_reg_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_GUARD,
    WR_DATA,
    WR_ISSUE,
    RD_ISSUE,
    RD_CAPTURE,
    SEND,
    GUARD
  } state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Cycle counter that clears while clr is high, counts enabled cycles and flags
// expiry at LIMIT-1; used by the bridge only when UART_REG_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-command parser between the buart receiver/transmitter and a register bus.
// Define UART_REG_TIMEOUT_EN to abandon a write whose data byte never arrives.
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter int CLK_FREQUENCY = 60_000_000,
  parameter int TIMEOUT_MS    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              uart_rd,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              uart_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rd_data
);

  localparam int TIMEOUT_CYCLES = CLK_FREQUENCY / 1000 * TIMEOUT_MS;

  state_e            state_q, state_d;
  logic              uart_rd_q, uart_rd_d;
  logic              uart_wr_q, uart_wr_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              timeout_expired;

`ifdef UART_REG_TIMEOUT_EN
  // Counter sits cleared outside WR_DATA, so every entry starts from zero.
  uart_cmd_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q != WR_DATA),
    .en     ((state_q == WR_DATA) && !rx_valid),
    .expired(timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_expired    = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    uart_rd_d     = 1'b0;
    uart_wr_d     = 1'b0;
    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    tx_data_d     = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          uart_rd_d  = 1'b1;
          reg_addr_d = rx_data[ADDR_W-1:0];
          state_d    = rx_data[CMD_WR_BIT] ? WR_GUARD : RD_ISSUE;
        end
      end
      // buart still shows the consumed command byte for one more cycle.
      WR_GUARD: state_d = WR_DATA;
      WR_DATA: begin
        if (rx_valid) begin
          uart_rd_d     = 1'b1;
          reg_wr_data_d = rx_data;
          state_d       = WR_ISSUE;
        end else if (timeout_expired) begin
          state_d = IDLE;
        end
      end
      WR_ISSUE: begin
        reg_wr_d = 1'b1;
        state_d  = GUARD;
      end
      RD_ISSUE: begin
        reg_rd_d = 1'b1;
        state_d  = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        tx_data_d = reg_rd_data;
        state_d   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          uart_wr_d = 1'b1;
          state_d   = GUARD;
        end
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      uart_rd_q     <= 1'b0;
      uart_wr_q     <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      uart_rd_q     <= uart_rd_d;
      uart_wr_q     <= uart_wr_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign uart_rd     = uart_rd_q;
  assign uart_wr     = uart_wr_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: a buart model feeds bytes, a monitor
// pops expected register/UART events and checks values and cycle latencies.
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       uart_rd;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       uart_wr;
  logic [6:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rd_data;

  uart_reg_bridge #(
    .CLK_FREQUENCY(1_000_000),
    .TIMEOUT_MS   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .uart_rd    (uart_rd),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .uart_wr    (uart_wr),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  typedef enum int { EV_WR, EV_RD, EV_TX } ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       addr;
    int       data;
    int       lat;   // cycles after the latest uart_rd, -1 = unchecked
    int       at;    // absolute cycle, -1 = unchecked
  } ev_t;

  ev_t        sbq[$];
  logic [7:0] rxq[$];
  int         rd_cycles[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_rd_cyc = 0;
  logic       rd_pending = 1'b0;
  logic [3:0] prev_strobes = 4'b0000;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(ev_kind_e k, int a, int d, int lat, int at);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.lat = lat; e.at = at;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // buart model: consumed byte leaves the FIFO at the edge after uart_rd is seen,
  // and rx_valid/rx_data only reflect that one cycle later.
  always @(negedge clk) rd_pending = uart_rd;
  always @(posedge clk) begin
    if (rd_pending && rxq.size() != 0) void'(rxq.pop_front());
    rx_valid <= (rxq.size() != 0);
    rx_data  <= (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic handle(input ev_kind_e k, input string nm);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=strobe expected=none (cycle %0d)", nm, cyc);
      return;
    end
    e = sbq.pop_front();
    check({nm, "_kind"}, int'(k), int'(e.kind));
    if (k == EV_WR || k == EV_RD) check({nm, "_addr"}, int'(reg_addr), e.addr);
    if (k == EV_WR) check({nm, "_data"}, int'(reg_wr_data), e.data);
    if (k == EV_TX) check({nm, "_data"}, int'(tx_data), e.data);
    if (e.lat >= 0) check({nm, "_latency"}, cyc - last_rd_cyc, e.lat);
    if (e.at >= 0) check({nm, "_cycle"}, cyc, e.at);
  endtask

  always @(negedge clk) begin
    logic [3:0] s;
    if (!reset) begin
      s = {uart_rd, uart_wr, reg_wr, reg_rd};
      if (s != 4'b0000) begin
        check("strobe_onehot", $countones(s), 1);
        check("strobe_single_cycle", int'(s & prev_strobes), 0);
      end
      if (reg_wr) handle(EV_WR, "reg_wr");
      if (reg_rd) handle(EV_RD, "reg_rd");
      if (uart_wr) handle(EV_TX, "uart_wr");
      if (uart_rd) begin
        rd_cycles.push_back(cyc);
        last_rd_cyc = cyc;
      end
      prev_strobes = s;
    end else begin
      prev_strobes = 4'b0000;
    end
  end

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_pending expected=0_pending", nm, sbq.size());
      sbq.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_uart_rd"}, int'(uart_rd), 0);
    check({nm, "_uart_wr"}, int'(uart_wr), 0);
    check({nm, "_reg_wr"}, int'(reg_wr), 0);
    check({nm, "_reg_rd"}, int'(reg_rd), 0);
    check({nm, "_reg_addr"}, int'(reg_addr), 0);
    check({nm, "_reg_wr_data"}, int'(reg_wr_data), 0);
    check({nm, "_tx_data"}, int'(tx_data), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    tx_busy     = 1'b0;
    reg_rd_data = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single write: 0x85 0x3C -> reg_wr(0x05, 0x3C), no uart_wr.
    sbq.push_back(mk(EV_WR, 'h05, 'h3C, 1, -1));
    rxq.push_back(8'h85);
    rxq.push_back(8'h3C);
    drain("write", 50);
    check("write_addr_hold", int'(reg_addr), 'h05);
    check("write_data_hold", int'(reg_wr_data), 'h3C);

    // Single read: 0x12 with 0xA7 on the bus -> uart_wr 3 cycles after uart_rd.
    reg_rd_data = 8'hA7;
    sbq.push_back(mk(EV_RD, 'h12, 0, 1, -1));
    sbq.push_back(mk(EV_TX, 0, 'hA7, 3, -1));
    rxq.push_back(8'h12);
    drain("read", 50);
    check("read_tx_hold", int'(tx_data), 'hA7);

    // Back-pressure: tx_busy high 200 cycles, uart_wr the cycle after it falls.
    tx_busy     = 1'b1;
    reg_rd_data = 8'h5E;
    sbq.push_back(mk(EV_RD, 'h33, 0, 1, -1));
    rxq.push_back(8'h33);
    repeat (200) @(negedge clk);
    check("bp_no_early_send", sbq.size(), 0);
    sbq.push_back(mk(EV_TX, 0, 'h5E, -1, cyc + 1));
    tx_busy = 1'b0;
    drain("backpressure", 20);

    // Back-to-back queued commands: write(0x01,0x11) then read(0x02).
    reg_rd_data = 8'hC4;
    rd_cycles.delete();
    sbq.push_back(mk(EV_WR, 'h01, 'h11, 1, -1));
    sbq.push_back(mk(EV_RD, 'h02, 0, 1, -1));
    sbq.push_back(mk(EV_TX, 0, 'hC4, 3, -1));
    rxq.push_back(8'h81);
    rxq.push_back(8'h11);
    rxq.push_back(8'h02);
    drain("b2b", 60);
    check("b2b_rd_count", rd_cycles.size(), 3);
    if (rd_cycles.size() == 3) begin
      check("b2b_data_spacing", rd_cycles[1] - rd_cycles[0], 2);
      check("b2b_cmd_spacing", rd_cycles[2] - rd_cycles[0], 5);
    end

    // Slow data byte: the bridge waits in WR_DATA.
    sbq.push_back(mk(EV_WR, 'h0A, 'h77, 1, -1));
    rxq.push_back(8'h8A);
    repeat (50) @(negedge clk);
    rxq.push_back(8'h77);
    drain("slow_write", 50);

    // Reset while waiting for write data discards the partial command.
    rxq.push_back(8'h90);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    sbq.push_back(mk(EV_WR, 'h10, 'h55, 1, -1));
    rxq.push_back(8'h90);
    rxq.push_back(8'h55);
    drain("post_reset_write", 50);

`ifdef UART_REG_TIMEOUT_EN
    // Timeout: 0x83 without data; after ~1000 idle cycles 0x04 must decode as a read.
    rxq.push_back(8'h83);
    repeat (1100) @(negedge clk);
    reg_rd_data = 8'h6B;
    sbq.push_back(mk(EV_RD, 'h04, 0, 1, -1));
    sbq.push_back(mk(EV_TX, 0, 'h6B, 3, -1));
    rxq.push_back(8'h04);
    drain("timeout_read", 50);
`endif

    check("rx_fifo_empty", rxq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
